// File: rtl/fpu.sv
// Single-precision IEEE-754 add/subtract unit with one registered result per clock.
// Round to nearest, ties to even. Subnormals are handled on input and output.

package pa_fpu;
  typedef enum logic [1:0] {
    op_add = 2'd0,
    op_sub = 2'd1,
    op_mul = 2'd2,
    op_div = 2'd3
  } e_fpu_op;
endpackage

module fpu (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      a_operand,
  input  logic [31:0]      b_operand,
  input  pa_fpu::e_fpu_op  operation,
  output logic [31:0]      ieee_packet_out
);

  localparam logic [31:0] QNAN    = 32'h7fc0_0000;
  localparam logic [30:0] INF_MAG = 31'h7f80_0000;

  // Number of leading zeros in a 27-bit word (27 when the word is zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Round a normalized mantissa carrying guard/round/sticky to nearest even.
  // Bit 24 of the result flags a mantissa overflow that needs renormalizing.
  function automatic logic [24:0] round_ne(input logic [26:0] m);
    logic rnd_up;
    rnd_up = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[26:3]} + {24'd0, rnd_up};
  endfunction

  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b, eff_a, eff_b;
  logic [23:0] m_a, m_b;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic        a_is_big;
  logic        s_big, s_small;
  logic [7:0]  e_big, e_small, diff, max_sh;
  logic [23:0] m_big, m_small;
  logic [26:0] big_ext, small_ext, shifted, lost_mask, aligned, norm;
  logic [27:0] sum;
  logic [4:0]  lz, sh;
  logic [9:0]  e_norm, e_fin;
  logic [24:0] mant25;
  logic [23:0] mant24;
  logic [31:0] result;

  // Unpack, align, add, normalize, round and resolve special operands.
  always_comb begin
    sign_a = a_operand[31];
    sign_b = b_operand[31] ^ (operation == pa_fpu::op_sub);
    exp_a  = a_operand[30:23];
    exp_b  = b_operand[30:23];
    m_a    = {exp_a != 8'd0, a_operand[22:0]};
    m_b    = {exp_b != 8'd0, b_operand[22:0]};
    eff_a  = (exp_a == 8'd0) ? 8'd1 : exp_a;
    eff_b  = (exp_b == 8'd0) ? 8'd1 : exp_b;
    nan_a  = (exp_a == 8'hff) && (a_operand[22:0] != 23'd0);
    nan_b  = (exp_b == 8'hff) && (b_operand[22:0] != 23'd0);
    inf_a  = (exp_a == 8'hff) && (a_operand[22:0] == 23'd0);
    inf_b  = (exp_b == 8'hff) && (b_operand[22:0] == 23'd0);
    zero_a = (a_operand[30:0] == 31'd0);
    zero_b = (b_operand[30:0] == 31'd0);

    // Larger magnitude becomes the reference operand so subtraction never goes negative.
    a_is_big = {eff_a, m_a} >= {eff_b, m_b};
    s_big    = a_is_big ? sign_a : sign_b;
    s_small  = a_is_big ? sign_b : sign_a;
    e_big    = a_is_big ? eff_a  : eff_b;
    e_small  = a_is_big ? eff_b  : eff_a;
    m_big    = a_is_big ? m_a    : m_b;
    m_small  = a_is_big ? m_b    : m_a;
    diff     = e_big - e_small;

    big_ext   = {m_big, 3'b000};
    small_ext = {m_small, 3'b000};
    shifted   = small_ext >> diff[4:0];
    lost_mask = (27'd1 << diff[4:0]) - 27'd1;
    if (diff >= 8'd27) begin
      aligned = {26'd0, |m_small};
    end else begin
      aligned = {shifted[26:1], shifted[0] | (|(small_ext & lost_mask))};
    end

    if (s_big == s_small) begin
      sum = {1'b0, big_ext} + {1'b0, aligned};
    end else begin
      sum = {1'b0, big_ext} - {1'b0, aligned};
    end

    // Carry-out shifts right; otherwise shift left, never past the subnormal exponent.
    lz     = lzc27(sum[26:0]);
    max_sh = e_big - 8'd1;
    sh     = 5'd0;
    if (sum[27]) begin
      norm   = {sum[27:2], |sum[1:0]};
      e_norm = {2'b00, e_big} + 10'd1;
    end else begin
      sh     = ({3'b000, lz} < max_sh) ? lz : max_sh[4:0];
      norm   = sum[26:0] << sh;
      e_norm = {2'b00, e_big} - {5'd0, sh};
    end

    mant25 = round_ne(norm);
    if (mant25[24]) begin
      mant24 = mant25[24:1];
      e_fin  = e_norm + 10'd1;
    end else begin
      mant24 = mant25[23:0];
      e_fin  = e_norm;
    end

    // A subnormal that rounds up into bit 23 naturally becomes exponent field 1.
    if (e_fin >= 10'd255) begin
      result = {s_big, INF_MAG};
    end else begin
      result = {s_big, (mant24[23] ? e_fin[7:0] : 8'd0), mant24[22:0]};
    end
    if (sum == 28'd0) begin
      result = 32'd0;
    end

    if (operation == pa_fpu::op_mul || operation == pa_fpu::op_div) begin
      result = QNAN;
    end else if (nan_a || nan_b) begin
      result = QNAN;
    end else if (inf_a && inf_b) begin
      result = (sign_a == sign_b) ? {sign_a, INF_MAG} : QNAN;
    end else if (inf_a) begin
      result = {sign_a, INF_MAG};
    end else if (inf_b) begin
      result = {sign_b, INF_MAG};
    end else if (zero_a && zero_b) begin
      result = {sign_a & sign_b, 31'd0};
    end
  end

  // Output register; reset overrides any operation presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ieee_packet_out <= 32'd0;
    end else begin
      ieee_packet_out <= result;
    end
  end

endmodule

// File: tb/tb_fpu.sv
// Self-checking bench for the fpu add/subtract unit.
module tb_fpu;

  logic             clk;
  logic             rst;
  logic [31:0]      a_operand;
  logic [31:0]      b_operand;
  pa_fpu::e_fpu_op  operation;
  logic [31:0]      ieee_packet_out;

  int checks;
  int failures;

  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  fpu dut (
    .clk             (clk),
    .rst             (rst),
    .a_operand       (a_operand),
    .b_operand       (b_operand),
    .operation       (operation),
    .ieee_packet_out (ieee_packet_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact reference: each operand as an integer count of 2^-149 units, summed exactly,
  // then rounded once to binary32 with nearest-even.
  function automatic logic [31:0] ref_fpu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [31:0]  bb;
    logic [283:0] ma, mb, mag, keep, rem, half, one;
    logic         s;
    int           p, shift, expo;
    bb = b;
    if (op == 2'd1) bb[31] = ~bb[31];
    if (op >= 2'd2) return QNAN;
    if ((a[30:23] == 8'hff && a[22:0] != 0) || (bb[30:23] == 8'hff && bb[22:0] != 0)) return QNAN;
    if (a[30:23] == 8'hff && bb[30:23] == 8'hff) return (a[31] == bb[31]) ? a : QNAN;
    if (a[30:23] == 8'hff) return a;
    if (bb[30:23] == 8'hff) return bb;
    if (a[30:0] == 0 && bb[30:0] == 0) return {a[31] & bb[31], 31'd0};
    one = 284'd1;
    ma = 284'({a[30:23] != 0, a[22:0]});
    mb = 284'({bb[30:23] != 0, bb[22:0]});
    if (a[30:23] != 0) ma = ma << (a[30:23] - 1);
    if (bb[30:23] != 0) mb = mb << (bb[30:23] - 1);
    if (a[31] == bb[31]) begin
      mag = ma + mb; s = a[31];
    end else if (ma >= mb) begin
      mag = ma - mb; s = a[31];
    end else begin
      mag = mb - ma; s = bb[31];
    end
    if (mag == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 284; i++) if (mag[i]) p = i;
    if (p <= 23) return {s, mag[30:0]};
    shift = p - 23;
    keep  = mag >> shift;
    rem   = mag - (keep << shift);
    half  = one << (shift - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    expo = shift + 1;
    if (keep == (one << 24)) begin
      keep = keep >> 1;
      expo = expo + 1;
    end
    if (expo >= 255) return {s, 31'h7f80_0000};
    return {s, 8'(expo), keep[22:0]};
  endfunction

  // Present one operation before an edge; the caller samples 1 time unit after it.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    @(negedge clk);
    a_operand = a;
    b_operand = b;
    operation = pa_fpu::e_fpu_op'(op);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(32'h3f80_0000, 32'h3f80_0000, 2'd0);
    checks++;
    if (ieee_packet_out !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_hold got=%h want=%h", ieee_packet_out, 32'h0);
    end
    drive(32'h3f80_0000, 32'h3f80_0000, 2'd0);
    checks++;
    if (ieee_packet_out !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_priority got=%h want=%h", ieee_packet_out, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ieee_packet_out !== 32'h4000_0000) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", ieee_packet_out, 32'h4000_0000);
    end
  endtask

  task automatic test_directed;
    vec_t q[$];
    q.push_back({32'h3fffffff, 32'h402df854, 2'd0, 32'h4096fc2a});
    q.push_back({32'h41800000, 32'h42000000, 2'd0, 32'h42400000});
    q.push_back({32'h3f800000, 32'h3f8ccccd, 2'd1, 32'hbdccccd0});
    q.push_back({32'h3e800000, 32'h3f000000, 2'd1, 32'hbe800000});
    q.push_back({32'h007fffff, 32'h007fffff, 2'd0, 32'h00fffffe});
    q.push_back({32'h00400000, 32'h00400000, 2'd0, 32'h00800000});
    q.push_back({32'h007fffff, 32'h00000001, 2'd0, 32'h00800000});
    q.push_back({32'h00800000, 32'h00000001, 2'd1, 32'h007fffff});
    q.push_back({32'h00700000, 32'h000fffff, 2'd1, 32'h00600001});
    q.push_back({32'h00000001, 32'h80000001, 2'd0, 32'h00000000});
    q.push_back({32'h80000001, 32'h00000000, 2'd0, 32'h80000001});
    q.push_back({32'h80000001, 32'h00000001, 2'd1, 32'h80000002});
    q.push_back({32'h00000000, 32'h3f800000, 2'd1, 32'hbf800000});
    q.push_back({32'h00000001, 32'h80000000, 2'd1, 32'h00000001});
    q.push_back({32'h80000000, 32'h80000000, 2'd0, 32'h80000000});
    q.push_back({32'h80000000, 32'h00000000, 2'd1, 32'h80000000});
    q.push_back({32'h3f800000, 32'h3f800000, 2'd1, 32'h00000000});
    q.push_back({32'h7f7fffff, 32'h7f7fffff, 2'd0, 32'h7f800000});
    q.push_back({32'hff7fffff, 32'h7f7fffff, 2'd1, 32'hff800000});
    q.push_back({32'hff800000, 32'h7f800000, 2'd0, QNAN});
    q.push_back({32'h7f800000, 32'h7f800000, 2'd1, QNAN});
    q.push_back({32'h7f800000, 32'h7f800000, 2'd0, 32'h7f800000});
    q.push_back({32'h41200000, 32'hff800000, 2'd1, 32'h7f800000});
    q.push_back({32'h00000000, 32'h7f800000, 2'd1, 32'hff800000});
    q.push_back({32'h7fc00000, 32'h402df854, 2'd0, QNAN});
    q.push_back({32'h7fc00000, 32'h402df854, 2'd1, QNAN});
    q.push_back({32'h402df854, 32'h7fc00000, 2'd0, QNAN});
    q.push_back({32'h402df854, 32'h7fc00000, 2'd1, QNAN});
    q.push_back({32'hff800001, 32'h3f800000, 2'd0, QNAN});
    q.push_back({32'h3f800000, 32'h3f800000, 2'd2, QNAN});
    q.push_back({32'h3f800000, 32'h3f800000, 2'd3, QNAN});
    q.push_back({32'h3f800000, 32'h33800000, 2'd0, 32'h3f800000});
    q.push_back({32'h3f800001, 32'h33800000, 2'd0, 32'h3f800002});
    foreach (q[i]) begin
      drive(q[i].a, q[i].b, q[i].op);
      checks++;
      if (ieee_packet_out !== q[i].exp) begin
        failures++;
        $display("FAIL directed_%0d a=%h b=%h op=%0d got=%h want=%h",
                 i, q[i].a, q[i].b, q[i].op, ieee_packet_out, q[i].exp);
      end
    end
  endtask

  // Random operands biased towards close exponents, subnormals and special values.
  function automatic logic [31:0] pick_operand(input logic [31:0] other);
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v = v;
      1: v = {v[31], other[30:23], v[22:0]};
      2: v = {v[31], 8'(other[30:23] + 8'($urandom_range(0, 4)) - 8'd2), v[22:0]};
      3: v = {v[31], 8'd0, v[22:0]};
      4: v = {v[31], 8'($urandom_range(250, 254)), v[22:0]};
      default: v = {other[31] ^ v[0], other[30:1], v[1]};
    endcase
    return v;
  endfunction

  task automatic test_random;
    logic [31:0] a, b, want;
    logic [1:0]  op;
    for (int n = 0; n < 3000; n++) begin
      a    = $urandom;
      b    = pick_operand(a);
      op   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      want = ref_fpu(a, b, op);
      drive(a, b, op);
      checks++;
      if (ieee_packet_out !== want) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h op=%0d got=%h want=%h", n, a, b, op,
                 ieee_packet_out, want);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] want;
    drive(32'h41800000, 32'h42000000, 2'd0);
    drive(32'h3e800000, 32'h3f000000, 2'd1);
    checks++;
    want = 32'hbe800000;
    if (ieee_packet_out !== want) begin
      failures++;
      $display("FAIL back_to_back got=%h want=%h", ieee_packet_out, want);
    end
    // Inputs held steady must keep the output steady.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ieee_packet_out !== want) begin
        failures++;
        $display("FAIL hold_%0d got=%h want=%h", k, ieee_packet_out, want);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    a_operand = 32'd0;
    b_operand = 32'd0;
    operation = pa_fpu::op_add;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
